// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined add/subtract unit. The carry chain is cut into STAGES = WIDTH/GROUP
// registered stages; stage k resolves bit group k with a GROUP-bit carry
// look-ahead from the carry registered by stage k-1. One operation per cycle is
// accepted under a valid/ready handshake with full backpressure. Results leave
// in issue order.
//
//   add      : {C, answer} = operator_1 +  operator_2 +  operator_3
//   subtract : {C, answer} = operator_1 + ~operator_2 + ~operator_3
//
// Build option:
//   PIPE_ADDER_FLAGS_EN  when defined, adds the V (signed overflow) and
//                        Z (answer == 0) outputs and their registers.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of GROUP
//   GROUP  bits resolved per pipeline stage
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   flush       synchronous, drops every in-flight operation
//   in_valid    operation presented
//   in_ready    unit can accept this cycle (combinational from out_ready)
//   mode        0 = add, 1 = subtract
//   operator_1  first operand
//   operator_2  second operand
//   operator_3  carry-in for add, borrow-in for subtract
//   out_valid   result presented
//   out_ready   consumer accepts result
//   answer      result
//   C           carry-out of the MSB (for subtract, 1 = no borrow)
//   V           signed overflow            (PIPE_ADDER_FLAGS_EN only)
//   Z           answer == 0                (PIPE_ADDER_FLAGS_EN only)
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] operator_1,
    input  logic [WIDTH-1:0] operator_2,
    input  logic             operator_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] answer,
    output logic             C
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             V,
    output logic             Z
`endif
);

    localparam int STAGES = WIDTH / GROUP;
    // Intermediate data registers exist for stages 0..STAGES-2; the last
    // stage's data lives in the output registers.
    localparam int PIPE_DEPTH = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage payload. 'a' and 'b' carry the full operands forward (the
    // already-consumed low groups are never read again); 'res' collects the
    // resolved low groups; 'carry' is the carry into the next group.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             carry;
    } stage_t;

    stage_t             pipe_q    [PIPE_DEPTH];
    stage_t             src_stage [STAGES];
    stage_t             nxt_stage [STAGES];
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  src_valid;
    logic [STAGES-1:0]  adv;

    logic [WIDTH-1:0]   answer_q;
    logic               c_q;
`ifdef PIPE_ADDER_FLAGS_EN
    logic               v_q;
    logic               z_q;
`endif

    // GROUP-bit look-ahead add. Every carry is expanded directly from the bit
    // generate/propagate terms and the group carry-in, so no carry ripples
    // from one bit to the next. Returns {carry_out, sum}.
    function automatic logic [GROUP:0] group_add(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        // NOTE: blocking assignments here (and in always_comb) because each
        // line consumes the value computed just above it; only always_ff
        // blocks use non-blocking assignments.
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    // Advance chain, evaluated from the output backwards: a stage may load
    // when it is empty or when its content moves on this cycle.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = !valid_q[STAGES-1] || out_ready;
        adv[STAGES-1] = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt    = !valid_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    assign in_ready = adv[0];

    // Stage inputs and the group each stage resolves.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional/loop assignment so no latch can be inferred.
        src_stage = '{default: '0};
        nxt_stage = '{default: '0};
        src_valid = '0;

        // Stage 0 applies the subtract inversion to operand 2 and the
        // carry-in (borrow-in 1 becomes carry-in 0).
        src_stage[0].a     = operator_1;
        src_stage[0].b     = mode ? ~operator_2 : operator_2;
        src_stage[0].res   = '0;
        src_stage[0].carry = operator_3 ^ mode;
        src_valid[0]       = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            src_stage[k] = pipe_q[k-1];
            src_valid[k] = valid_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            nxt_stage[k] = src_stage[k];
            {nxt_stage[k].carry, nxt_stage[k].res[k*GROUP +: GROUP]} =
                group_add(src_stage[k].a[k*GROUP +: GROUP],
                          src_stage[k].b[k*GROUP +: GROUP],
                          src_stage[k].carry);
        end
    end

    // Valid bits and output registers. Flush clears only the valid bits, and
    // wins over a same-cycle input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            answer_q <= '0;
            c_q      <= 1'b0;
`ifdef PIPE_ADDER_FLAGS_EN
            v_q      <= 1'b0;
            z_q      <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush)       valid_q[k] <= 1'b0;
                else if (adv[k]) valid_q[k] <= src_valid[k];
            end
            // Output registers only load with a real operation, so they hold
            // steady while stalled and across bubbles.
            if (adv[STAGES-1] && src_valid[STAGES-1]) begin
                answer_q <= nxt_stage[STAGES-1].res;
                c_q      <= nxt_stage[STAGES-1].carry;
`ifdef PIPE_ADDER_FLAGS_EN
                v_q      <= (nxt_stage[STAGES-1].a[WIDTH-1] == nxt_stage[STAGES-1].b[WIDTH-1]) &&
                            (nxt_stage[STAGES-1].res[WIDTH-1] != nxt_stage[STAGES-1].a[WIDTH-1]);
                z_q      <= (nxt_stage[STAGES-1].res == '0);
`endif
            end
        end
    end

    // NOTE: intermediate data registers are deliberately not reset; their
    // contents are ignored whenever the matching valid bit is 0, so reset
    // only needs to reach the valid bits and the visible outputs.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) begin
            if (adv[k] && src_valid[k]) pipe_q[k] <= nxt_stage[k];
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign answer    = answer_q;
    assign C         = c_q;
`ifdef PIPE_ADDER_FLAGS_EN
    assign V         = v_q;
    assign Z         = z_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Scoreboard bench for pipelined_adder (default WIDTH=32, GROUP=8). The
// expected result of every accepted operation is queued at the cycle it is
// accepted; each cycle that out_valid is high the head of the queue is
// compared (so stalled outputs are re-checked every cycle) and popped when
// out_ready accepts it. V/Z are checked when PIPE_ADDER_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int W      = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [W-1:0] ans;
        logic         c;
        logic         v;
        logic         z;
        int           cyc;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] operator_1;
    logic [W-1:0] operator_2;
    logic         operator_3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] answer;
    logic         C;
`ifdef PIPE_ADDER_FLAGS_EN
    logic         V;
    logic         Z;
`endif

    pipelined_adder #(.WIDTH(W), .GROUP(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .operator_1 (operator_1),
        .operator_2 (operator_2),
        .operator_3 (operator_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .answer     (answer),
        .C          (C)
`ifdef PIPE_ADDER_FLAGS_EN
        ,
        .V          (V),
        .Z          (Z)
`endif
    );

    always #5 clk = ~clk;

    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   cyc             = 0;
    exp_t sb[$];
    exp_t cur_exp;
    bit   lat_flag;
    bit   head_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definition.
    function automatic exp_t model(input logic m, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
        exp_t         e;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   s;
        bb    = m ? ~b : b;
        cc    = m ? ~ci : ci;
        s     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        e.ans = s[W-1:0];
        e.c   = s[W];
        e.v   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        e.z   = (s[W-1:0] == '0);
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        exp_t item;
        if (rst) begin
            sb.delete();
            head_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        // Cycles from the one the op was presented in to the
                        // first cycle its result is visible.
                        if (sb[0].lat) check("latency", 64'(cyc - sb[0].cyc), 64'(STAGES));
                    end
                    check("answer", 64'(answer), 64'(sb[0].ans));
                    check("carry",  64'(C),      64'(sb[0].c));
`ifdef PIPE_ADDER_FLAGS_EN
                    check("V", 64'(V), 64'(sb[0].v));
                    check("Z", 64'(Z), 64'(sb[0].z));
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (flush) begin
                sb.delete();
                head_seen = 1'b0;
            end else if (in_valid && in_ready) begin
                item     = cur_exp;
                item.cyc = cyc;
                item.lat = lat_flag;
                sb.push_back(item);
            end
        end
    end

    // One cycle: observe the handshake at the falling edge, return at
    // rising edge + 1 ready to drive the next cycle.
    task automatic tick(output bit fired);
        @(negedge clk);
        fired = in_valid && in_ready && !flush;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
        mode       = m;
        operator_1 = a;
        operator_2 = b;
        operator_3 = ci;
        in_valid   = 1'b1;
    endtask

    // Present one op and hold it until accepted (bounded).
    task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input exp_t e, input bit lat);
        bit f;
        int guard;
        set_op(m, a, b, ci);
        cur_exp  = e;
        lat_flag = lat;
        guard    = 0;
        f        = 1'b0;
        while (!f && guard < 100) begin
            tick(f);
            guard++;
        end
        if (!f) check("issue_timeout", 64'(f), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic issue_rand(input bit lat);
        logic [W-1:0] a, b;
        logic         m, ci;
        a  = $urandom;
        b  = $urandom;
        m  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        issue(m, a, b, ci, model(m, a, b, ci), lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (sb.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_answer"},    64'(answer),    64'd0);
        check({tag, "_C"},         64'(C),         64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
`ifdef PIPE_ADDER_FLAGS_EN
        check({tag, "_V"}, 64'(V), 64'd0);
        check({tag, "_Z"}, 64'(Z), 64'd0);
`endif
    endtask

    // Directed vectors: mode, op1, op2, op3, expected answer, C, V, Z.
    typedef struct {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] ans;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t dir_vecs[10] = '{
        '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
        '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
        '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0},
        '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
        '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
        '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 32'h00FF_00FF, 32'h0001_FF01, 1'b0, 32'h0101_0000, 1'b0, 1'b0, 1'b0},
        '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bit   f;
        int   accepted;

        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        mode       = 1'b0;
        operator_1 = '0;
        operator_2 = '0;
        operator_3 = 1'b0;
        out_ready  = 1'b1;
        lat_flag   = 1'b0;
        head_seen  = 1'b0;
        cur_exp    = model(1'b0, '0, '0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");

        // Directed then random back-to-back ops, no backpressure.
        foreach (dir_vecs[i]) begin
            e     = model(1'b0, '0, '0, 1'b0);
            e.ans = dir_vecs[i].ans;
            e.c   = dir_vecs[i].c;
            e.v   = dir_vecs[i].v;
            e.z   = dir_vecs[i].z;
            issue(dir_vecs[i].m, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].ci, e, 1'b1);
        end
        for (int i = 0; i < 20; i++) issue_rand(1'b1);
        drain();

        // Backpressure: 6 ops offered with out_ready low, only 4 fit.
        out_ready = 1'b0;
        lat_flag  = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || f) begin
                operator_1 = $urandom;
                operator_2 = $urandom;
                mode       = 1'($urandom_range(0, 1));
                operator_3 = 1'($urandom_range(0, 1));
                cur_exp    = model(mode, operator_1, operator_2, operator_3);
            end
            in_valid = 1'b1;
            tick(f);
            if (f) accepted++;
        end
        check("stall_accepted", 64'(accepted), 64'(STAGES));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (3) begin
            tick(f);
        end
        check("stall_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            check("drain_one_per_cycle", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_done", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("drain_queue", 64'(sb.size()), 64'd0);

        // Random traffic with random backpressure.
        lat_flag = 1'b0;
        f        = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!in_valid || f) begin
                if ($urandom_range(0, 3) != 0) begin
                    operator_1 = $urandom;
                    operator_2 = $urandom;
                    mode       = 1'($urandom_range(0, 1));
                    operator_3 = 1'($urandom_range(0, 1));
                    cur_exp    = model(mode, operator_1, operator_2, operator_3);
                    in_valid   = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(f);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush with 3 ops in flight, together with a new input.
        for (int i = 0; i < 3; i++) issue_rand(1'b0);
        set_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        flush = 1'b1;
        tick(f);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            check("flush_no_out", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("flush_queue", 64'(sb.size()), 64'd0);
        issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1,
              model(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1), 1'b1);
        drain();

        // Reset mid-stream with a result held at the output.
        out_ready = 1'b0;
        issue_rand(1'b0);
        issue_rand(1'b0);
        repeat (STAGES) tick(f);
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        issue(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0,
              model(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0), 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
